vxe_vpu_wrq_arb: RTL
====================

Name: vxe_vpu_wrq_arb

Overview:
- Two-requester arbiter for the single LSU write-request channel in the VPU.
- Sits between two store-side sources (store execution units or other VPU write sources) and the LSU write-request port.
- Applies round-robin arbitration with a bounded ownership burst.
- Registers the winning request in a one-entry output stage, which cuts the combinational path from the LSU ready back to the sources and sustains one beat per cycle.

Parameters:
- BURST_MAX, 4: maximum consecutive beats granted to one requester while the other is waiting; legal range 1..15.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_rq0_wr  in  1  requester 0 beat valid (driven from a register)
- i_rq0_th  in  3  requester 0 thread id
- i_rq0_addr  in  37  requester 0 64-bit-word address
- i_rq0_wen  in  2  requester 0 word enables {hi,lo}
- i_rq0_data  in  64  requester 0 data {hi,lo}
- o_rq0_rdy  out  1  requester 0 beat accepted this cycle
- i_rq1_wr, i_rq1_th, i_rq1_addr, i_rq1_wen, i_rq1_data  in  1/3/37/2/64  requester 1, same meaning as requester 0
- o_rq1_rdy  out  1  requester 1 beat accepted this cycle
- i_lsu_wrq_rdy  in  1  LSU consumed the current output beat
- o_lsu_wrq_wr  out  1  output beat valid
- o_lsu_wrq_th  out  3  output thread id
- o_lsu_wrq_addr  out  37  output address
- o_lsu_wrq_wen  out  2  output word enables
- o_lsu_wrq_data  out  64  output data
- o_lsu_wrq_src  out  1  index of the requester that owns the output beat
- o_busy  out  1  output stage holds a beat, or any requester is asserting wr

Behaviour:
- Reset (nrst low, asynchronous): o_lsu_wrq_wr=0; th/addr/wen/data/src=0; last-grant pointer lg=1, so requester 0 wins first; burst counter bc=0. With nrst low, o_rq0_rdy=o_rq1_rdy=0.
- Transfer definitions:
  - Requester side: a beat transfers when i_rqN_wr && o_rqN_rdy.
  - LSU side: a beat transfers when o_lsu_wrq_wr && i_lsu_wrq_rdy.
  - The LSU may hold rdy low indefinitely; the output payload stays stable until consumed.
- can_acc = !o_lsu_wrq_wr || i_lsu_wrq_rdy.
- Grant select g is combinational. It is evaluated only when at least one wr is high:
  - Only one requester asserts wr: g = that requester.
  - Both assert wr: g = lg if bc < BURST_MAX; otherwise g = ~lg.
- o_rqN_rdy = can_acc && i_rqN_wr && (g==N). At most one rdy is high per cycle. There is no combinational path from rdy to wr.
- On accept (any o_rqN_rdy high), next edge:
  - Load the output stage from requester g; o_lsu_wrq_wr=1; o_lsu_wrq_src=g.
  - If g==lg, bc=bc+1, saturating at BURST_MAX. Otherwise lg=g, bc=1.
- LSU consumes with no new accept: o_lsu_wrq_wr=0 next edge. Payload registers keep their values.
- Simultaneous consume and accept: the new beat replaces the old one in the same edge. Throughput is 1 beat/cycle with no bubble.
- Latency: a requester beat accepted at edge k is presented on the LSU port from edge k+1.
- Idle requester: bc is not reset, so a sole requester streams indefinitely. The burst limit applies only under contention.
- Ordering: beats from one requester reach the LSU in acceptance order. There is no reordering and no write combining; sources combine before this block.
- wen: passed through unmodified. wen=2'b00 is forwarded as-is; it is the source's error.
- Reset mid-operation: the beat in the output stage is dropped and arbitration state returns to reset values. Sources must be reset by the same nrst.

Decomposition:
- Shared VPU package/header: LSU write-request field widths (TH_W=3, ADDR_W=37, WEN_W=2, DATA_W=64) and the wen encodings WEN_LO=2'b01, WEN_HI=2'b10, WEN_BOTH=2'b11.
- One natural sub-module, vxe_rr_arb2: the two-way round-robin and burst-counter grant logic (lg, bc, g). It is reusable for the read-request channel.
- The payload mux and output register stay in the top module.

Test Plan:
- Single requester streaming: rq0 asserts 6 beats (addr 0x10..0x15, wen 2'b11), i_lsu_wrq_rdy=1 constant. Required: LSU sees addr 0x10..0x15 on 6 consecutive cycles, first one cycle after the first rdy, src=0; rq1_rdy never asserts.
- Contention with BURST_MAX=4: both requesters assert continuously, 8 beats each, LSU rdy=1. Required: LSU src sequence is 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 and each requester's addresses stay in order.
- LSU backpressure: rq1 beat addr 0x7, data 0xDEADBEEF_00000001, wen 2'b10, LSU rdy=0 for 5 cycles. Required: o_lsu_wrq_wr=1 with stable payload for all 5 cycles and o_rq1_rdy=0 after the first accept; on rdy=1, the next rq1 beat loads on the same edge.
- Consume with no new request: one rq0 beat, then wr drops; LSU rdy=1. Required: o_lsu_wrq_wr high exactly 1 cycle; o_busy falls the cycle after consume.
- Async reset mid-stream: assert nrst low between edges while o_lsu_wrq_wr=1. Required: o_lsu_wrq_wr=0 and payload=0 immediately (not waiting for a clock edge); after release with both requesting, requester 0 is granted first.
- Alternating requesters: rq0 and rq1 assert on alternating cycles only. Required: each beat is accepted the cycle it appears, src alternates 0,1,0,1, and no beat is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/vxe_vpu_wrq_arb_pkg.sv
// Shared VPU LSU write-request definitions: field widths, word-enable encodings
// and the beat record carried through the write-request arbiter.
package vxe_vpu_wrq_arb_pkg;

   localparam int TH_W   = 3;
   localparam int ADDR_W = 37;
   localparam int WEN_W  = 2;
   localparam int DATA_W = 64;

   // Burst counter width covers the full legal BURST_MAX range of 1..15.
   localparam int BC_W   = 4;

   localparam logic [WEN_W-1:0] WEN_LO   = 2'b01;
   localparam logic [WEN_W-1:0] WEN_HI   = 2'b10;
   localparam logic [WEN_W-1:0] WEN_BOTH = 2'b11;

   typedef enum logic {
      SRC_RQ0 = 1'b0,
      SRC_RQ1 = 1'b1
   } wrq_src_e;

   typedef struct packed {
      logic [TH_W-1:0]   th;
      logic [ADDR_W-1:0] addr;
      logic [WEN_W-1:0]  wen;
      logic [DATA_W-1:0] data;
   } wrq_beat_t;

   function automatic wrq_beat_t make_beat(
      input logic [TH_W-1:0]   th,
      input logic [ADDR_W-1:0] addr,
      input logic [WEN_W-1:0]  wen,
      input logic [DATA_W-1:0] data
   );
      wrq_beat_t b;
      b.th   = th;
      b.addr = addr;
      b.wen  = wen;
      b.data = data;
      return b;
   endfunction

endpackage

// File: rtl/vxe_vpu_wrq_arb_rr_arb2.sv
// Two-way round-robin grant with a bounded ownership burst. Holds the last-grant
// pointer and burst counter; the grant itself is purely combinational.
module vxe_rr_arb2
   import vxe_vpu_wrq_arb_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [1:0] req,
   input  logic       adv,
   output logic       gnt,
   output logic       gnt_vld
);

   localparam logic [BC_W-1:0] BMAX = BC_W'(BURST_MAX);

   logic            lg;
   logic [BC_W-1:0] bc;
   logic            keep_owner;

   // bc==0 only occurs out of reset: no burst is running, so the pointer rotates
   // and requester 0 wins the first contended grant.
   assign keep_owner = (bc != '0) && (bc < BMAX);
   assign gnt_vld    = |req;

   always_comb begin
      gnt = 1'b0;
      unique case (req)
         2'b01:   gnt = 1'b0;
         2'b10:   gnt = 1'b1;
         2'b11:   gnt = keep_owner ? lg : ~lg;
         default: gnt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lg <= 1'b1;
         bc <= '0;
      end else if (adv) begin
         if (gnt == lg) begin
            if (bc < BMAX) begin
               bc <= bc + 1'b1;
            end
         end else begin
            lg <= gnt;
            bc <= BC_W'(1);
         end
      end
   end

endmodule

// File: rtl/vxe_vpu_wrq_arb.sv
// Two-requester arbiter for the VPU LSU write-request channel: round-robin grant
// with bounded bursts, feeding a one-entry registered output stage.
module vxe_vpu_wrq_arb
   import vxe_vpu_wrq_arb_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              nrst,

   input  logic              i_rq0_wr,
   input  logic [TH_W-1:0]   i_rq0_th,
   input  logic [ADDR_W-1:0] i_rq0_addr,
   input  logic [WEN_W-1:0]  i_rq0_wen,
   input  logic [DATA_W-1:0] i_rq0_data,
   output logic              o_rq0_rdy,

   input  logic              i_rq1_wr,
   input  logic [TH_W-1:0]   i_rq1_th,
   input  logic [ADDR_W-1:0] i_rq1_addr,
   input  logic [WEN_W-1:0]  i_rq1_wen,
   input  logic [DATA_W-1:0] i_rq1_data,
   output logic              o_rq1_rdy,

   input  logic              i_lsu_wrq_rdy,
   output logic              o_lsu_wrq_wr,
   output logic [TH_W-1:0]   o_lsu_wrq_th,
   output logic [ADDR_W-1:0] o_lsu_wrq_addr,
   output logic [WEN_W-1:0]  o_lsu_wrq_wen,
   output logic [DATA_W-1:0] o_lsu_wrq_data,
   output logic              o_lsu_wrq_src,

   output logic              o_busy
);

   logic      gnt;
   logic      gnt_vld;
   logic      can_acc;
   logic      accept;
   wrq_beat_t beat0;
   wrq_beat_t beat1;
   wrq_beat_t sel_beat;
   wrq_beat_t out_q;
   logic      out_vld;
   wrq_src_e  out_src;

   vxe_rr_arb2 #(
      .BURST_MAX (BURST_MAX)
   ) u_rr_arb2 (
      .clk     (clk),
      .nrst    (nrst),
      .req     ({i_rq1_wr, i_rq0_wr}),
      .adv     (accept),
      .gnt     (gnt),
      .gnt_vld (gnt_vld)
   );

   // The output stage can take a beat when empty or when the LSU drains it this
   // cycle. Ready is also held low while reset is asserted.
   assign can_acc   = !out_vld || i_lsu_wrq_rdy;
   assign o_rq0_rdy = nrst && can_acc && gnt_vld && i_rq0_wr && (gnt == 1'b0);
   assign o_rq1_rdy = nrst && can_acc && gnt_vld && i_rq1_wr && (gnt == 1'b1);
   assign accept    = o_rq0_rdy || o_rq1_rdy;

   always_comb begin
      beat0    = make_beat(i_rq0_th, i_rq0_addr, i_rq0_wen, i_rq0_data);
      beat1    = make_beat(i_rq1_th, i_rq1_addr, i_rq1_wen, i_rq1_data);
      sel_beat = gnt ? beat1 : beat0;
   end

   // A new accept overwrites the stage in the same edge as a consume, so the
   // channel sustains one beat per cycle; payload is kept when the stage empties.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_vld <= 1'b0;
         out_q   <= '0;
         out_src <= SRC_RQ0;
      end else if (accept) begin
         out_vld <= 1'b1;
         out_q   <= sel_beat;
         out_src <= wrq_src_e'(gnt);
      end else if (i_lsu_wrq_rdy) begin
         out_vld <= 1'b0;
      end
   end

   assign o_lsu_wrq_wr   = out_vld;
   assign o_lsu_wrq_th   = out_q.th;
   assign o_lsu_wrq_addr = out_q.addr;
   assign o_lsu_wrq_wen  = out_q.wen;
   assign o_lsu_wrq_data = out_q.data;
   assign o_lsu_wrq_src  = out_src;
   assign o_busy         = out_vld || i_rq0_wr || i_rq1_wr;

endmodule
